fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of decode and the ALU/register-file datapath.
- Generates sequential PCs and issues requests to instruction memory over a valid/ready request channel.
- Buffers returned words, with their PCs, in a QDEPTH-entry queue and presents them downstream with a valid/ready handshake.
- Handles control-flow redirects (branch taken on EQ, jumps) by flushing the queue and discarding in-flight responses.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Issues sequential word-aligned
//                fetch requests under a credit limit, queues returned words
//                with their PCs, and presents them downstream. Redirects
//                flush the queue and squash responses still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int                 D_WIDTH  = 32,
   parameter logic [D_WIDTH-1:0] RESET_PC = '0,
   parameter int                 QDEPTH   = 2    // power of 2, >= 2
) (
   input  logic               clk,
   input  logic               rst_n,
   // instruction memory request channel
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [D_WIDTH-1:0] imem_req_addr,
   // instruction memory response channel (always accepted)
   input  logic               imem_rsp_valid,
   input  logic [D_WIDTH-1:0] imem_rsp_data,
   // control-flow redirect
   input  logic               redirect_valid,
   input  logic [D_WIDTH-1:0] redirect_target,
   // downstream instruction channel
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [D_WIDTH-1:0] instr_data,
   output logic [D_WIDTH-1:0] instr_pc
);

   localparam int                 c_PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int                 c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(QDEPTH);

   // architectural state
   logic [D_WIDTH-1:0] r_fetch_pc;
   logic [D_WIDTH-1:0] r_rsp_pc;
   logic [c_CNT_W-1:0] r_outstanding;
   logic [c_CNT_W-1:0] r_drop_cnt;
   logic [c_CNT_W-1:0] r_count;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [D_WIDTH-1:0] r_q_pc    [QDEPTH];
   logic [D_WIDTH-1:0] r_q_instr [QDEPTH];

   // combinational helpers
   logic [c_CNT_W:0]   w_credit;
   logic               w_req_fire;
   logic               w_rsp_take;
   logic               w_push;
   logic               w_pop;
   logic [D_WIDTH-1:0] w_target;
   logic [c_CNT_W-1:0] w_inflight;
   logic [c_CNT_W-1:0] w_out_next;
   logic [1:0]         w_unused_tgt_lsb;

   // Queue slots plus in-flight requests may never exceed the queue depth,
   // so every response that comes back is guaranteed somewhere to land.
   assign w_credit       = {1'b0, r_count} + {1'b0, r_outstanding};
   assign imem_req_valid = rst_n & ~redirect_valid & (w_credit < {1'b0, c_DEPTH});
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid & imem_req_ready;

   // A response with nothing outstanding is a protocol violation and is ignored.
   assign w_rsp_take = imem_rsp_valid & (r_outstanding != '0);
   assign w_push     = w_rsp_take & (r_drop_cnt == '0) & ~redirect_valid;

   assign instr_valid = rst_n & (r_count != '0) & ~redirect_valid;
   assign instr_data  = r_q_instr[r_rd_ptr];
   assign instr_pc    = r_q_pc[r_rd_ptr];
   assign w_pop       = instr_valid & instr_ready;

   assign w_target         = {redirect_target[D_WIDTH-1:2], 2'b00};
   assign w_unused_tgt_lsb = redirect_target[1:0];

   // Responses still owed by memory after this cycle. Pending drops are a
   // subset of the outstanding requests, so this figure already covers them
   // and can never exceed the queue depth.
   assign w_inflight = r_outstanding - c_CNT_W'(w_rsp_take);

   // Outstanding count: +1 per accepted request, -1 per returned response.
   always_comb begin
      w_out_next = r_outstanding;
      if (w_req_fire) w_out_next = w_out_next + c_CNT_W'(1);
      if (w_rsp_take) w_out_next = w_out_next - c_CNT_W'(1);
   end

   // Queue storage: capture kept responses together with their PC.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[r_wr_ptr]    <= r_rsp_pc;
         r_q_instr[r_wr_ptr] <= imem_rsp_data;
      end
   end

   // Control state: PCs, credit counters and queue pointers; redirect wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
      end else begin
         r_outstanding <= w_out_next;
         if (redirect_valid) begin
            r_fetch_pc <= w_target;
            r_rsp_pc   <= w_target;
            r_drop_cnt <= w_inflight;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
         end else begin
            if (w_req_fire) begin
               r_fetch_pc <= r_fetch_pc + D_WIDTH'(4);
            end
            if (w_rsp_take) begin
               if (r_drop_cnt != '0) begin
                  r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
               end else begin
                  r_rsp_pc <= r_rsp_pc + D_WIDTH'(4);
               end
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + c_CNT_W'(1);
               2'b01:   r_count <= r_count - c_CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit with a simple
//                in-order instruction memory model (1-cycle response).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;

   int total = 0;
   int bad   = 0;

   // memory model and monitors
   logic        rsp_en;
   logic [31:0] pend [$];
   logic [31:0] reqs [$];
   logic [63:0] got  [$];
   logic        last_req_v;
   logic [31:0] last_req_addr;
   logic        last_instr_v;

   fetch_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr_data      (instr_data),
      .instr_pc        (instr_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] fdata(input logic [31:0] a);
      return a ^ 32'hA5C3_0F0F;
   endfunction

   // One clock cycle: observe at negedge, then let memory answer after the edge.
   task automatic tick();
      logic        fire;
      logic [31:0] faddr;
      @(negedge clk);
      last_req_v    = imem_req_valid;
      last_req_addr = imem_req_addr;
      last_instr_v  = instr_valid;
      fire  = imem_req_valid & imem_req_ready;
      faddr = imem_req_addr;
      if (fire) reqs.push_back(faddr);
      if (instr_valid & instr_ready) got.push_back({instr_pc, instr_data});
      @(posedge clk);
      #1;
      if (fire) pend.push_back(faddr);
      if (rsp_en && pend.size() != 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = fdata(pend.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
   endtask

   task automatic apply_reset();
      rst_n           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = '0;
      imem_req_ready  = 1'b1;
      instr_ready     = 1'b1;
      rsp_en          = 1'b1;
      imem_rsp_valid  = 1'b0;
      imem_rsp_data   = '0;
      pend.delete();
      tick();
      tick();
      reqs.delete();
      got.delete();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (last_req_v !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%0b exp=0", last_req_v); end
      total++; if (last_instr_v !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%0b exp=0", last_instr_v); end
      tick();
      total++; if (last_req_v !== 1'b1) begin bad++; $display("FAIL reset_first_req_valid got=%0b exp=1", last_req_v); end
      total++; if (last_req_addr !== 32'h0) begin bad++; $display("FAIL reset_first_addr got=%h exp=00000000", last_req_addr); end
      total++; if (last_instr_v !== 1'b0) begin bad++; $display("FAIL reset_empty_queue got=%0b exp=0", last_instr_v); end
   endtask

   task automatic test_stream();
      logic [31:0] epc;
      apply_reset();
      repeat (3) tick();
      total++; if (got.size() != 1) begin bad++; $display("FAIL stream_latency got=%0d exp=1", got.size()); end
      repeat (9) tick();
      total++; if (reqs.size() != 8) begin bad++; $display("FAIL stream_req_count got=%0d exp=8", reqs.size()); end
      total++; if (got.size() != 7) begin bad++; $display("FAIL stream_instr_count got=%0d exp=7", got.size()); end
      for (int i = 0; i < 8; i++) begin
         epc = 32'(4 * i);
         total++; if (reqs[i] !== epc) begin bad++; $display("FAIL stream_req[%0d] got=%h exp=%h", i, reqs[i], epc); end
      end
      for (int i = 0; i < 7; i++) begin
         epc = 32'(4 * i);
         total++; if (got[i] !== {epc, fdata(epc)}) begin bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, got[i], {epc, fdata(epc)}); end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      instr_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i >= 2) begin
            total++; if (last_req_v !== 1'b0) begin bad++; $display("FAIL bp_req_blocked c%0d got=%0b exp=0", i, last_req_v); end
         end
      end
      total++; if (reqs.size() != 2) begin bad++; $display("FAIL bp_req_count got=%0d exp=2", reqs.size()); end
      total++; if (reqs[0] !== 32'h0 || reqs[1] !== 32'h4) begin bad++; $display("FAIL bp_req_addrs got=%h,%h exp=0,4", reqs[0], reqs[1]); end
      total++; if (last_instr_v !== 1'b1) begin bad++; $display("FAIL bp_head_valid got=%0b exp=1", last_instr_v); end
      total++; if (instr_pc !== 32'h0 || instr_data !== fdata(32'h0)) begin bad++; $display("FAIL bp_head_stable got=%h/%h exp=0/%h", instr_pc, instr_data, fdata(32'h0)); end
      instr_ready = 1'b1;
      tick();
      total++; if (reqs.size() != 2) begin bad++; $display("FAIL bp_no_req_on_pop got=%0d exp=2", reqs.size()); end
      tick();
      total++; if (reqs.size() != 3 || reqs[2] !== 32'h8) begin bad++; $display("FAIL bp_req_after_pop got=%0d/%h exp=3/8", reqs.size(), reqs[2]); end
      repeat (2) tick();
      total++; if (got.size() != 3) begin bad++; $display("FAIL bp_instr_count got=%0d exp=3", got.size()); end
      for (int i = 0; i < 3; i++) begin
         logic [31:0] epc;
         epc = 32'(4 * i);
         total++; if (got[i] !== {epc, fdata(epc)}) begin bad++; $display("FAIL bp_instr[%0d] got=%h exp=%h", i, got[i], {epc, fdata(epc)}); end
      end
   endtask

   task automatic test_redirect();
      apply_reset();
      rsp_en = 1'b0;
      repeat (2) tick();
      redirect_valid  = 1'b1;
      redirect_target = 32'h100;
      tick();
      total++; if (last_req_v !== 1'b0) begin bad++; $display("FAIL redir_req_blocked got=%0b exp=0", last_req_v); end
      redirect_valid = 1'b0;
      rsp_en         = 1'b1;
      repeat (7) tick();
      total++; if (got.size() != 2) begin bad++; $display("FAIL redir_instr_count got=%0d exp=2", got.size()); end
      total++; if (got[0] !== {32'h100, fdata(32'h100)}) begin bad++; $display("FAIL redir_first got=%h exp=%h", got[0], {32'h100, fdata(32'h100)}); end
      total++; if (got[1] !== {32'h104, fdata(32'h104)}) begin bad++; $display("FAIL redir_second got=%h exp=%h", got[1], {32'h104, fdata(32'h104)}); end
      total++; if (reqs[2] !== 32'h100 || reqs[3] !== 32'h104) begin bad++; $display("FAIL redir_req_addrs got=%h,%h exp=100,104", reqs[2], reqs[3]); end
   endtask

   task automatic test_redirect_rsp();
      apply_reset();
      rsp_en = 1'b0;
      tick();
      rsp_en = 1'b1;
      tick();
      redirect_valid  = 1'b1;
      redirect_target = 32'h203;
      tick();
      redirect_valid = 1'b0;
      tick();
      total++; if (last_req_v !== 1'b1 || last_req_addr !== 32'h200) begin bad++; $display("FAIL redrsp_next_req got=%0b/%h exp=1/200", last_req_v, last_req_addr); end
      repeat (3) tick();
      total++; if (got.size() != 2) begin bad++; $display("FAIL redrsp_instr_count got=%0d exp=2", got.size()); end
      total++; if (got[0] !== {32'h200, fdata(32'h200)}) begin bad++; $display("FAIL redrsp_first got=%h exp=%h", got[0], {32'h200, fdata(32'h200)}); end
      total++; if (got[1] !== {32'h204, fdata(32'h204)}) begin bad++; $display("FAIL redrsp_second got=%h exp=%h", got[1], {32'h204, fdata(32'h204)}); end
   endtask

   task automatic test_redirect_gate();
      apply_reset();
      tick();
      redirect_valid  = 1'b1;
      redirect_target = 32'h40;
      tick();
      total++; if (last_req_v !== 1'b0) begin bad++; $display("FAIL gate_req_valid got=%0b exp=0", last_req_v); end
      redirect_valid = 1'b0;
      repeat (2) tick();
      redirect_valid  = 1'b1;
      redirect_target = 32'h80;
      tick();
      total++; if (last_instr_v !== 1'b0) begin bad++; $display("FAIL gate_instr_valid got=%0b exp=0", last_instr_v); end
      redirect_valid = 1'b0;
      repeat (3) tick();
      total++; if (got.size() != 1) begin bad++; $display("FAIL gate_instr_count got=%0d exp=1", got.size()); end
      total++; if (got[0] !== {32'h80, fdata(32'h80)}) begin bad++; $display("FAIL gate_first got=%h exp=%h", got[0], {32'h80, fdata(32'h80)}); end
   endtask

   task automatic test_stall();
      logic [31:0] epc;
      apply_reset();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (last_req_v !== 1'b1 || last_req_addr !== 32'h0) begin bad++; $display("FAIL stall_hold c%0d got=%0b/%h exp=1/0", i, last_req_v, last_req_addr); end
      end
      total++; if (reqs.size() != 0) begin bad++; $display("FAIL stall_no_accept got=%0d exp=0", reqs.size()); end
      imem_req_ready = 1'b1;
      repeat (8) tick();
      total++; if (reqs.size() != 6 || got.size() != 4) begin bad++; $display("FAIL stall_counts got=%0d/%0d exp=6/4", reqs.size(), got.size()); end
      for (int i = 0; i < 4; i++) begin
         epc = 32'(4 * i);
         total++; if (got[i] !== {epc, fdata(epc)}) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, got[i], {epc, fdata(epc)}); end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      instr_ready = 1'b0;
      repeat (4) tick();
      total++; if (last_instr_v !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%0b exp=1", last_instr_v); end
      rst_n          = 1'b0;
      imem_rsp_valid = 1'b0;
      pend.delete();
      tick();
      total++; if (last_instr_v !== 1'b0 || last_req_v !== 1'b0) begin bad++; $display("FAIL rmid_during got=%0b/%0b exp=0/0", last_instr_v, last_req_v); end
      rst_n = 1'b1;
      tick();
      total++; if (last_instr_v !== 1'b0) begin bad++; $display("FAIL rmid_after_valid got=%0b exp=0", last_instr_v); end
      total++; if (last_req_v !== 1'b1 || last_req_addr !== 32'h0) begin bad++; $display("FAIL rmid_after_req got=%0b/%h exp=1/0", last_req_v, last_req_addr); end
   endtask

   task automatic test_wrap();
      apply_reset();
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      repeat (4) tick();
      total++; if (reqs.size() < 2 || reqs[0] !== 32'hFFFF_FFFC || reqs[1] !== 32'h0) begin bad++; $display("FAIL wrap_reqs got=%h,%h exp=fffffffc,0", reqs[0], reqs[1]); end
      total++; if (got.size() != 2) begin bad++; $display("FAIL wrap_instr_count got=%0d exp=2", got.size()); end
      total++; if (got[0] !== {32'hFFFF_FFFC, fdata(32'hFFFF_FFFC)}) begin bad++; $display("FAIL wrap_last got=%h exp=%h", got[0], {32'hFFFF_FFFC, fdata(32'hFFFF_FFFC)}); end
      total++; if (got[1] !== {32'h0, fdata(32'h0)}) begin bad++; $display("FAIL wrap_zero got=%h exp=%h", got[1], {32'h0, fdata(32'h0)}); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_rsp();
      test_redirect_gate();
      test_stall();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
